// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the N-approach traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    GREEN     = 2'd1,
    YELLOW    = 2'd2,
    EMG_GREEN = 2'd3
  } state_t;

  // Width of an approach index; never below one bit.
  function automatic int dir_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational next-approach selector: first demanding approach after the
// current one (current one checked last), or plain rotation when nothing waits.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int SKIP_EMPTY = 1,
  localparam int DW        = dir_w(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] i_sensor,
  input  logic [DW-1:0]      i_cur_dir,
  output logic [DW-1:0]      o_next_dir
);

  int   w_idx;
  logic w_found;

  always_comb begin
    w_idx      = 0;
    w_found    = 1'b0;
    o_next_dir = DW'((int'(i_cur_dir) + 1) % NUM_DIR);
    if (SKIP_EMPTY != 0) begin
      for (int k = 1; k <= NUM_DIR; k++) begin
        w_idx = (int'(i_cur_dir) + k) % NUM_DIR;
        if (!w_found && i_sensor[w_idx]) begin
          o_next_dir = DW'(w_idx);
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-approach traffic-light controller: GREEN -> YELLOW -> all-red CLEAR per
// approach, demand-actuated skipping and emergency pre-emption handshake.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_T    = 8,
  parameter int YELLOW_T   = 4,
  parameter int RED_T      = 2,
  parameter int SKIP_EMPTY = 1,
  localparam int DW        = dir_w(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] sensor,
  input  logic               emg_req,
  input  logic [DW-1:0]      emg_dir,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic               emg_ack,
  output logic [DW-1:0]      cur_dir
);

  localparam int TW = $clog2(max3(GREEN_T, YELLOW_T, RED_T)) + 1;
  localparam logic [TW-1:0] G_LD = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] Y_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] R_LD = TW'(RED_T - 1);
  localparam logic [DW:0]   N_LIM = (DW + 1)'(NUM_DIR);

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [DW-1:0]      r_cur;
  logic [NUM_DIR-1:0] r_green;
  logic [NUM_DIR-1:0] r_yellow;
  logic [NUM_DIR-1:0] r_red;
  logic               r_ack;

  state_t             w_state_nxt;
  logic [TW-1:0]      w_timer_nxt;
  logic [DW-1:0]      w_cur_nxt;
  logic [DW-1:0]      w_pick;
  logic               w_emg_ok;
  logic [NUM_DIR-1:0] w_oh;
  logic [NUM_DIR-1:0] w_green_nxt;
  logic [NUM_DIR-1:0] w_yellow_nxt;

  traffic_rr_pick #(
    .NUM_DIR    (NUM_DIR),
    .SKIP_EMPTY (SKIP_EMPTY)
  ) u_pick (
    .i_sensor   (sensor),
    .i_cur_dir  (r_cur),
    .o_next_dir (w_pick)
  );

  // Out-of-range emergency targets are treated as no request at all.
  assign w_emg_ok = emg_req && ({1'b0, emg_dir} < N_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer - TW'(1);
    w_cur_nxt   = r_cur;
    case (r_state)
      CLEAR: begin
        if (r_timer == '0) begin
          if (w_emg_ok) begin
            w_state_nxt = EMG_GREEN;
            w_cur_nxt   = emg_dir;
            w_timer_nxt = '0;
          end else begin
            w_state_nxt = GREEN;
            w_cur_nxt   = w_pick;
            w_timer_nxt = G_LD;
          end
        end
      end
      GREEN: begin
        if (w_emg_ok && (emg_dir == r_cur)) begin
          w_state_nxt = EMG_GREEN;
          w_timer_nxt = '0;
        end else if (w_emg_ok || (r_timer == '0)) begin
          w_state_nxt = YELLOW;
          w_timer_nxt = Y_LD;
        end
      end
      YELLOW: begin
        if (r_timer == '0) begin
          w_state_nxt = CLEAR;
          w_timer_nxt = R_LD;
        end
      end
      EMG_GREEN: begin
        // Held without timing; the target is latched at entry.
        w_timer_nxt = '0;
        if (!emg_req) begin
          w_state_nxt = YELLOW;
          w_timer_nxt = Y_LD;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_timer_nxt = R_LD;
      end
    endcase
  end

  // Lamps are decoded from the next state so they switch on the state edge.
  assign w_oh         = NUM_DIR'(1) << w_cur_nxt;
  assign w_green_nxt  = ((w_state_nxt == GREEN) || (w_state_nxt == EMG_GREEN)) ? w_oh : '0;
  assign w_yellow_nxt = (w_state_nxt == YELLOW) ? w_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= CLEAR;
      r_timer  <= R_LD;
      r_cur    <= DW'(NUM_DIR - 1);
      r_green  <= '0;
      r_yellow <= '0;
      r_red    <= '1;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_cur    <= w_cur_nxt;
      r_green  <= w_green_nxt;
      r_yellow <= w_yellow_nxt;
      r_red    <= ~(w_green_nxt | w_yellow_nxt);
      r_ack    <= (w_state_nxt == EMG_GREEN);
    end
  end

  assign green   = r_green;
  assign yellow  = r_yellow;
  assign red     = r_red;
  assign emg_ack = r_ack;
  assign cur_dir = r_cur;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed scoreboard bench: a 4-approach skipping controller and a 3-approach
// fixed-rotation controller, with per-cycle lamp invariant checks.
module tb_traffic_ctrl_n;

  localparam int K_G = 0;
  localparam int K_Y = 1;
  localparam int K_C = 2;
  localparam int K_E = 3;

  logic       clk;
  logic       rst;
  logic [3:0] sensor4;
  logic       emg_req4;
  logic [1:0] emg_dir4;
  logic [3:0] g4, y4, r4;
  logic       ack4;
  logic [1:0] cur4;
  logic [2:0] sensor3;
  logic       emg_req3;
  logic [1:0] emg_dir3;
  logic [2:0] g3, y3, r3;
  logic       ack3;
  logic [1:0] cur3;

  int n_tests;
  int n_fail;

  logic [14:0] q_exp[$];
  string       q_tag[$];

  traffic_ctrl_n #(
    .NUM_DIR(4), .GREEN_T(8), .YELLOW_T(4), .RED_T(2), .SKIP_EMPTY(1)
  ) u4 (
    .clk(clk), .rst(rst), .sensor(sensor4), .emg_req(emg_req4), .emg_dir(emg_dir4),
    .green(g4), .yellow(y4), .red(r4), .emg_ack(ack4), .cur_dir(cur4)
  );

  traffic_ctrl_n #(
    .NUM_DIR(3), .GREEN_T(3), .YELLOW_T(2), .RED_T(2), .SKIP_EMPTY(0)
  ) u3 (
    .clk(clk), .rst(rst), .sensor(sensor3), .emg_req(emg_req3), .emg_dir(emg_dir3),
    .green(g3), .yellow(y3), .red(r3), .emg_ack(ack3), .cur_dir(cur3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input int sel, input int dir, input int kind);
    logic [3:0] mask, oh, g, y, r;
    mask = (sel != 0) ? 4'b0111 : 4'b1111;
    oh   = 4'(1 << dir);
    g    = ((kind == K_G) || (kind == K_E)) ? oh : 4'b0000;
    y    = (kind == K_Y) ? oh : 4'b0000;
    r    = ~(g | y) & mask;
    return {g, y, r, (kind == K_E), 2'(dir)};
  endfunction

  task automatic cmp_pop(input int sel);
    logic [14:0] exp_v, obs_v;
    string       tag;
    exp_v = q_exp.pop_front();
    tag   = q_tag.pop_front();
    obs_v = (sel != 0) ? {1'b0, g3, 1'b0, y3, 1'b0, r3, ack3, cur3}
                       : {g4, y4, r4, ack4, cur4};
    n_tests++;
    assert (obs_v === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed {g,y,r,ack,cur}=%h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_now(input int sel, input int dir, input int kind, input string tag);
    q_exp.push_back(mk(sel, dir, kind));
    q_tag.push_back(tag);
    cmp_pop(sel);
  endtask

  // Expect n consecutive cycles of one lamp phase, sampled 1 time unit after each edge.
  task automatic phase(input int sel, input int dir, input int kind, input int n,
                       input string tag);
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(mk(sel, dir, kind));
      q_tag.push_back(tag);
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cmp_pop(sel);
    end
  endtask

  always @(negedge clk) begin
    n_tests++;
    assert ($onehot0(g4 | y4) && (r4 === ~(g4 | y4)) &&
            $onehot0(g3 | y3) && (r3 === ~(g3 | y3)))
    else begin
      n_fail++;
      $error("FAIL invariant: g4=%b y4=%b r4=%b g3=%b y3=%b r3=%b", g4, y4, r4, g3, y3, r3);
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    sensor4  = 4'b0000;
    emg_req4 = 1'b0;
    emg_dir4 = 2'd0;
    sensor3  = 3'b100;
    emg_req3 = 1'b0;
    emg_dir3 = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check_now(0, 3, K_C, "reset4");
    check_now(1, 2, K_C, "reset3");

    // Plain rotation with no demand anywhere.
    rst = 1'b1;
    phase(0, 3, K_C, 1, "first_clear");
    for (int d = 0; d < 4; d++) begin
      phase(0, d, K_G, 8, "rot_green");
      phase(0, d, K_Y, 4, "rot_yellow");
      phase(0, d, K_C, 2, "rot_clear");
    end
    phase(0, 0, K_G, 8, "rot_wrap");

    // Only approach 3 has demand: it alone is served, repeatedly.
    sensor4 = 4'b1000;
    phase(0, 0, K_Y, 4, "skip_y0");
    phase(0, 0, K_C, 2, "skip_c0");
    phase(0, 3, K_G, 8, "skip_g3");
    phase(0, 3, K_Y, 4, "skip_y3");
    phase(0, 3, K_C, 2, "skip_c3");
    phase(0, 3, K_G, 8, "skip_g3_again");
    sensor4 = 4'b0000;
    phase(0, 3, K_Y, 4, "rot_back_y3");
    phase(0, 3, K_C, 2, "rot_back_c3");
    phase(0, 0, K_G, 8, "rot_back_g0");
    phase(0, 0, K_Y, 4, "rot_back_y0");
    phase(0, 0, K_C, 2, "rot_back_c0");
    phase(0, 1, K_G, 3, "pre_emg_g1");

    // Pre-emption to a different approach truncates green, keeps clearance.
    emg_req4 = 1'b1;
    emg_dir4 = 2'd3;
    phase(0, 1, K_Y, 4, "emg_trunc_y1");
    phase(0, 1, K_C, 2, "emg_clear");
    phase(0, 3, K_E, 2, "emg_hold");
    emg_dir4 = 2'd0;
    phase(0, 3, K_E, 3, "emg_dir_change");
    emg_req4 = 1'b0;
    phase(0, 3, K_Y, 4, "emg_release_y3");
    phase(0, 3, K_C, 2, "emg_release_c3");
    phase(0, 0, K_G, 4, "resume_g0");

    // Pre-emption to the approach already green: no yellow gap.
    emg_req4 = 1'b1;
    emg_dir4 = 2'd0;
    phase(0, 0, K_E, 3, "emg_same");
    emg_req4 = 1'b0;
    phase(0, 0, K_Y, 4, "emg_same_y0");
    phase(0, 0, K_C, 2, "emg_same_c0");
    phase(0, 1, K_G, 8, "after_same_g1");
    phase(0, 1, K_Y, 2, "mid_yellow");

    // Asynchronous reset in the middle of yellow.
    rst = 1'b0;
    #2;
    check_now(0, 3, K_C, "async_rst4");
    check_now(1, 2, K_C, "async_rst3");
    emg_req3 = 1'b1;
    emg_dir3 = 2'd3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    phase(0, 3, K_C, 1, "post_rst_clear");
    phase(0, 0, K_G, 1, "post_rst_g0");

    // Three approaches, fixed rotation, out-of-range emergency held throughout.
    phase(1, 0, K_G, 2, "n3_g0");
    phase(1, 0, K_Y, 2, "n3_y0");
    phase(1, 0, K_C, 2, "n3_c0");
    phase(1, 1, K_G, 3, "n3_g1");
    phase(1, 1, K_Y, 2, "n3_y1");
    phase(1, 1, K_C, 2, "n3_c1");
    phase(1, 2, K_G, 3, "n3_g2");
    phase(1, 2, K_Y, 2, "n3_y2");
    phase(1, 2, K_C, 2, "n3_c2");
    phase(1, 0, K_G, 3, "n3_wrap_g0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_n.md
Name: traffic_ctrl_n

Overview:
- Parametrised N-approach traffic-light controller; successor to the fixed 4-way round-robin controller.
- Sequences GREEN -> YELLOW -> ALL-RED clearance per approach with counter-based, configurable timings.
- Adds vehicle-actuated skipping of empty approaches and an emergency pre-emption handshake.
- Sits in the intersection top level; drives lamp drivers directly from registered outputs.

Parameters:
- NUM_DIR, 4, number of approaches (2..16); approach index wraps NUM_DIR-1 -> 0.
- GREEN_T, 8, green duration in clk cycles (>=1).
- YELLOW_T, 4, yellow duration in clk cycles (>=1).
- RED_T, 2, all-red clearance duration in clk cycles (>=1).
- SKIP_EMPTY, 1, 1 = skip approaches with no sensor demand; 0 = fixed round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sensor  in  NUM_DIR  per-approach vehicle presence, synchronous to clk.
- emg_req  in  1  emergency pre-emption request, level, held until emg_ack seen.
- emg_dir  in  $clog2(NUM_DIR)  approach to pre-empt to; sampled while emg_req high.
- green  out  NUM_DIR  one-hot or zero; green lamp per approach.
- yellow  out  NUM_DIR  one-hot or zero; yellow lamp per approach.
- red  out  NUM_DIR  red lamp per approach; red[i] = ~(green[i] | yellow[i]).
- emg_ack  out  1  high while emg_dir is green under pre-emption.
- cur_dir  out  $clog2(NUM_DIR)  approach currently owning or last owning right-of-way.

Behaviour:
- Reset (rst=0, async):
  - State = CLEAR, cur_dir = NUM_DIR-1, timer = RED_T-1.
  - green = 0, yellow = 0, red = all ones, emg_ack = 0.
  - First green after reset goes to approach 0 (subject to skip rule).
- States: CLEAR, GREEN, YELLOW, EMG_GREEN.
- Timer: loaded with duration-1 on state entry; decrements each cycle; the state exits on the cycle timer==0. Each state therefore lasts exactly its duration.
- Outputs are registered and reflect the current state. Lamps change on the same edge as the state.
- CLEAR -> GREEN on timer expiry, with next-approach selection:
  - Pending emg_req: cur_dir <= emg_dir; go to EMG_GREEN.
  - Otherwise, with SKIP_EMPTY=1: cur_dir <= first i with sensor[i]=1, scanning (cur_dir+1) mod NUM_DIR upward with wrap; cur_dir itself is checked last.
  - If sensor == 0: cur_dir <= (cur_dir+1) mod NUM_DIR (plain rotation).
  - With SKIP_EMPTY=0: always (cur_dir+1) mod NUM_DIR.
- GREEN -> YELLOW after GREEN_T cycles.
- GREEN pre-emption: emg_req=1 with emg_dir != cur_dir forces YELLOW on the next edge, truncating green.
  - emg_req=1 with emg_dir == cur_dir: go directly to EMG_GREEN (green lamp stays continuous) and assert emg_ack.
- YELLOW -> CLEAR after YELLOW_T cycles. Yellow is never truncated.
- EMG_GREEN: green[cur_dir] = 1, emg_ack = 1, held while emg_req = 1 (no timer).
  - emg_req deasserts -> YELLOW (normal YELLOW_T), emg_ack -> 0 on the same edge.
  - emg_dir changes while in EMG_GREEN: ignored until the next request cycle.
- emg_req during YELLOW or CLEAR: the request is honoured at the CLEAR exit.
  - Clearance is never shortened; at least one YELLOW_T + RED_T separates conflicting greens.
- Invariant: at most one bit of (green | yellow) set in any cycle; red has at least NUM_DIR-1 bits set.
- emg_dir >= NUM_DIR: request ignored, emg_ack stays 0.
- Reset mid-operation: immediate all-red; timers and pre-emption abandoned.
- Timer width = $clog2(max(GREEN_T, YELLOW_T, RED_T)) + 1; no overflow possible.

Decomposition:
- Package traffic_pkg: state enum (CLEAR, GREEN, YELLOW, EMG_GREEN); a dir_idx width function.
- Sub-module traffic_rr_pick: combinational round-robin next-approach selector, inputs sensor, cur_dir, SKIP_EMPTY. Reusable and testable alone.
- Timer and FSM stay in the top module.

Test Plan:
- Reset then release, NUM_DIR=4, 8/4/2 timings, SKIP_EMPTY=0 -> green[0] first asserted after 2 cycles. Per approach: 8 cycles green, 4 yellow, 2 all-red. Order 0,1,2,3,0; period 56 cycles.
- SKIP_EMPTY=1, sensor=4'b1000 held -> only approach 3 gets green, repeatedly; sensor=0 -> plain rotation 0,1,2,3.
- Pre-emption: approach 1 green for 3 cycles, emg_req=1, emg_dir=3 -> 4 cycles yellow[1], then 2 all-red, then green[3] with emg_ack=1 held. Drop emg_req -> yellow[3] for 4 cycles, then normal rotation resumes.
- emg_req with emg_dir == cur_dir during GREEN -> green continuous, emg_ack asserted next edge, no yellow gap.
- Assert rst mid-YELLOW -> same cycle (async): all red=1, green=yellow=0, emg_ack=0. Release -> approach 0 green after RED_T.
- NUM_DIR=3, SKIP_EMPTY=0 -> wrap 2->0 verified; assertion checks the one-hot invariant every cycle; emg_dir=3 ignored.
